// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - stream/control bundle for the serial pattern detector
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             mode_overlap;
    logic             clear;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output in_valid, in, mode_overlap, clear, pat_load, pat_in,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
        input  in_valid, in, mode_overlap, clear, pat_load, pat_in,
        output out, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial bit-pattern detector with saturating match count
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               CNT_W   = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    seq_detect_param_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_r, pat_nx;
    logic [PAT_W-1:0]  hist, hist_nx, nh;
    logic [FILL_W-1:0] fill, fill_nx, nf;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              out_r, out_nx;
    logic              hit;

    // State register; reset restores the parameter pattern and empties the history.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_r <= PATTERN;
            hist  <= '0;
            fill  <= '0;
            cnt   <= '0;
            out_r <= 1'b0;
        end else begin
            pat_r <= pat_nx;
            hist  <= hist_nx;
            fill  <= fill_nx;
            cnt   <= cnt_nx;
            out_r <= out_nx;
        end
    end

    // Next-state: load beats clear beats an accepted bit; the pulse only lives one cycle.
    always_comb begin
        pat_nx  = pat_r;
        hist_nx = hist;
        fill_nx = fill;
        cnt_nx  = cnt;
        out_nx  = 1'b0;
        nh      = {hist[PAT_W-2:0], bus.in};
        nf      = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        hit     = (nf == FILL_FULL) && (nh == pat_r);
        if (bus.pat_load) begin
            pat_nx  = bus.pat_in;
            hist_nx = '0;
            fill_nx = '0;
        end else if (bus.clear) begin
            hist_nx = '0;
            fill_nx = '0;
            cnt_nx  = '0;
        end else if (bus.in_valid) begin
            hist_nx = nh;
            if (hit) begin
                out_nx = 1'b1;
                if (!(&cnt)) begin
                    cnt_nx = cnt + 1'b1;
                end
                // Non-overlap mode forces the next match to be built from fresh bits only.
                fill_nx = bus.mode_overlap ? FILL_FULL : '0;
            end else begin
                fill_nx = nf;
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = &cnt;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_d = 1'b0, in_d = 1'b0, ovl = 1'b1, clr = 1'b0, ld = 1'b0;
    logic [3:0] pin = 4'b0000;
    bit         run = 1'b0;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if8 ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if2 ();

    assign if8.in_valid = v_d;  assign if2.in_valid = v_d;
    assign if8.in = in_d;       assign if2.in = in_d;
    assign if8.mode_overlap = ovl; assign if2.mode_overlap = ovl;
    assign if8.clear = clr;     assign if2.clear = clr;
    assign if8.pat_load = ld;   assign if2.pat_load = ld;
    assign if8.pat_in = pin;    assign if2.pat_in = pin;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) dut8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if8.slave));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if2.slave));

    // Model: list of accepted bits since the last restart point; match = newest 4 equal the pattern.
    bit         hq[$];
    logic [3:0] m_pat = 4'b1101;
    int         m_cnt8 = 0, m_cnt2 = 0;
    bit         m_out = 1'b0;

    function automatic logic [3:0] last4();
        logic [3:0] w;
        for (int i = 0; i < 4; i++) w[3-i] = hq[hq.size()-4+i];
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hq.delete(); m_pat = 4'b1101; m_cnt8 = 0; m_cnt2 = 0; m_out = 1'b0;
        end else if (ld) begin
            m_pat = pin; hq.delete(); m_out = 1'b0;
        end else if (clr) begin
            hq.delete(); m_cnt8 = 0; m_cnt2 = 0; m_out = 1'b0;
        end else if (v_d) begin
            m_out = 1'b0;
            hq.push_back(in_d);
            if (hq.size() > 4) void'(hq.pop_front());
            if (hq.size() == 4 && last4() == m_pat) begin
                m_out  = 1'b1;
                m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
                if (!ovl) hq.delete();
            end
        end else begin
            m_out = 1'b0;
        end
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (run) begin
            cmp("out8", int'(if8.out), int'(m_out));
            cmp("cnt8", int'(if8.match_cnt), m_cnt8);
            cmp("sat8", int'(if8.cnt_sat), int'(m_cnt8 == 255));
            cmp("out2", int'(if2.out), int'(m_out));
            cmp("cnt2", int'(if2.match_cnt), m_cnt2);
            cmp("sat2", int'(if2.cnt_sat), int'(m_cnt2 == 3));
        end
    end

    task automatic send(input bit b, input bit v);
        @(negedge clk); in_d = b; v_d = v;
        @(posedge clk); #1; v_d = 1'b0; in_d = 1'b0;
    endtask

    // Bits are sent MSB first; exp_out gives the literal out value after each bit.
    task automatic sendv(input logic [31:0] bits, input int n, input logic [31:0] exp_out);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], 1'b1);
            cmp("lit_out", int'(if8.out), int'(exp_out[n-1-i]));
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        #1 run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_out", int'(if8.out), 0);
        cmp("rst_cnt", int'(if8.match_cnt), 0);
        cmp("rst_sat", int'(if2.cnt_sat), 0);
        @(negedge clk); rst_n = 1'b1;

        // Overlapping: 1101101 matches at bits 4 and 7.
        ovl = 1'b1;
        sendv(32'b1101101, 7, 32'b0001001);
        cmp("ovl_cnt", int'(if8.match_cnt), 2);

        do_clear();
        cmp("clr_cnt", int'(if8.match_cnt), 0);

        // Non-overlapping: only bit 4 matches; a further 1101 matches again.
        ovl = 1'b0;
        sendv(32'b1101101, 7, 32'b0001000);
        cmp("novl_cnt1", int'(if8.match_cnt), 1);
        sendv(32'b1101, 4, 32'b0001);
        cmp("novl_cnt2", int'(if8.match_cnt), 2);

        // Gap in in_valid keeps the partial sequence.
        do_clear();
        ovl = 1'b1;
        sendv(32'b11, 2, 32'b00);
        send(1'b1, 1'b0); cmp("gap_out", int'(if8.out), 0);
        send(1'b0, 1'b0); cmp("gap_out", int'(if8.out), 0);
        send(1'b1, 1'b0); cmp("gap_out", int'(if8.out), 0);
        sendv(32'b01, 2, 32'b01);
        cmp("gap_cnt", int'(if8.match_cnt), 1);

        // Saturation of the 2-bit counter over six back-to-back-ish matches.
        do_clear();
        sendv(32'b1101, 4, 32'b0001);
        cmp("sat_cnt2", int'(if2.match_cnt), 1);
        for (int k = 0; k < 5; k++) begin
            sendv(32'b101, 3, 32'b001);
            cmp("sat_cnt2", int'(if2.match_cnt), (k == 0) ? 2 : 3);
            cmp("sat_flag2", int'(if2.cnt_sat), (k >= 1) ? 1 : 0);
            cmp("sat_cnt8", int'(if8.match_cnt), k + 2);
        end
        do_clear();
        cmp("clr_cnt2", int'(if2.match_cnt), 0);
        cmp("clr_sat2", int'(if2.cnt_sat), 0);
        sendv(32'b101, 3, 32'b000);
        sendv(32'b1101, 4, 32'b0001);
        cmp("fresh_cnt", int'(if8.match_cnt), 1);

        // Pattern load wins over clear and in_valid.
        ovl = 1'b0;
        @(negedge clk); ld = 1'b1; pin = 4'b0110; clr = 1'b1; v_d = 1'b1; in_d = 1'b1;
        @(posedge clk); #1; ld = 1'b0; clr = 1'b0; v_d = 1'b0; in_d = 1'b0;
        cmp("load_cnt", int'(if8.match_cnt), 1);
        cmp("load_out", int'(if8.out), 0);
        sendv(32'b0110, 4, 32'b0001);
        cmp("newpat_cnt", int'(if8.match_cnt), 2);
        sendv(32'b1101, 4, 32'b0000);
        cmp("oldpat_cnt", int'(if8.match_cnt), 2);

        // Asynchronous reset drops a live pulse without a clock edge.
        sendv(32'b0110, 4, 32'b0001);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_out", int'(if8.out), 0);
        cmp("async_cnt", int'(if8.match_cnt), 0);
        @(negedge clk); rst_n = 1'b1;

        // Reset mid-sequence discards the partial pattern.
        ovl = 1'b1;
        sendv(32'b110, 3, 32'b000);
        @(negedge clk); rst_n = 1'b0;
        #1 cmp("midrst_out", int'(if8.out), 0);
        @(negedge clk); rst_n = 1'b1;
        sendv(32'b1, 1, 32'b0);
        sendv(32'b1101, 4, 32'b0001);
        cmp("postrst_cnt", int'(if8.match_cnt), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector for the sequential-logic lab set. Watches a qualified single-bit input stream for a PAT_W-bit pattern, raises a one-cycle registered match pulse and keeps a saturating match count. Pattern is reset-loaded from a parameter and can be reprogrammed at run time. Overlapping and non-overlapping detection are selectable per cycle.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1101: pattern loaded at reset; MSB is the oldest (first-received) bit.
- CNT_W, 8: match counter width; legal range 1..16.

- sys_clk  input  1  clock; all state changes on rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies `in`; bit accepted only when high.
- in  input  1  serial data bit.
- mode_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of history and counter.
- pat_load  input  1  synchronous load of new pattern.
- pat_in  input  PAT_W  pattern value captured when pat_load = 1.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all ones.

## Operation
- State: pattern register pat_r[PAT_W-1:0]; history shift register hist[PAT_W-1:0]; fill counter fill (0..PAT_W, saturating at PAT_W); match_cnt; out.
- Reset (async, sys_rst_n = 0): pat_r = PATTERN, hist = 0, fill = 0, out = 0, match_cnt = 0, cnt_sat = 0.
- Per-edge priority: pat_load > clear > in_valid > idle.
- pat_load = 1: pat_r <= pat_in; hist <= 0; fill <= 0; out <= 0; match_cnt unchanged; `in` this cycle discarded.
- clear = 1 (pat_load = 0): hist <= 0; fill <= 0; match_cnt <= 0; out <= 0; `in` discarded.
- in_valid = 1 (no load/clear): nh = {hist[PAT_W-2:0], in}; nf = min(fill+1, PAT_W). Match = (nf == PAT_W) && (nh == pat_r).
  - On match: out <= 1; match_cnt <= match_cnt + 1 unless all ones (holds); hist <= nh; fill <= PAT_W if mode_overlap = 1, else fill <= 0 (next match needs PAT_W fresh bits).
  - No match: out <= 0; hist <= nh; fill <= nf.
- in_valid = 0: out <= 0; hist, fill, match_cnt hold. Gaps in in_valid do not break a partial sequence.
- mode_overlap sampled only at the match edge; changing it between matches needs no flush.
- cnt_sat = combinational decode of match_cnt == all ones.
- Patterns with internal self-overlap (e.g. 1111, 1010) obey the same rules; no special cases.

## Timing
- Latency: out is high for exactly one cycle, beginning at the rising edge that samples the completing bit; match_cnt updates at that same edge.
- Back-to-back matches (overlap mode, periodic pattern) give out high on consecutive cycles; count increments each cycle.
- First possible match: the PAT_W-th accepted bit after reset, clear or pat_load.
- New pattern is effective for bits accepted from the cycle after pat_load.
- Reset asserted mid-sequence: all state returns to reset values immediately (asynchronously); out falls without waiting for a clock edge; deassertion is assumed synchronous to sys_clk by the upstream reset synchroniser.

## Test plan
- Defaults, overlap = 1, in_valid = 1, stream 1,1,0,1,1,0,1 -> out pulses after bits 4 and 7, match_cnt = 2.
- Same stream with overlap = 0 -> out pulse only after bit 4, match_cnt = 1; a further 1,1,0,1 -> second pulse, match_cnt = 2.
- Stream 1,1,(in_valid = 0 for 3 cycles, in toggling),0,1 -> single pulse after the final bit; no pulse during the gap.
- CNT_W = 2, six matches -> match_cnt 1,2,3,3,3,3; cnt_sat high from the third match; clear -> match_cnt = 0, cnt_sat = 0, next match needs 4 new bits.
- pat_load with pat_in = 4'b0110 asserted together with in_valid = 1 and clear = 1 -> bit discarded, match_cnt kept; then 0,1,1,0 -> pulse; 1,1,0,1 -> no pulse.
- Reset pulse after 1,1,0 (before final 1), then 1 -> no pulse; all outputs 0 during reset; following 1,1,0,1 -> pulse, match_cnt = 1.
